// File: rtl/axi_isolate_ctrl_if.sv
// axi_isolate_ctrl_if: AW/AR gate handshakes and observed response strobes around axi_isolate_ctrl
//   slv_*_valid / slv_*_ready : subsystem-side address handshake
//   mst_*_valid / mst_*_ready : CDC-side address handshake
//   b_hs, r_hs, r_last        : response handshakes, observed only
//   master modport: subsystem/CDC environment; slave modport: the isolation controller
interface axi_isolate_ctrl_if;
  logic slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
  logic slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
  logic b_hs, r_hs, r_last;
  modport master (
    output slv_aw_valid, mst_aw_ready, slv_ar_valid, mst_ar_ready, b_hs, r_hs, r_last,
    input  slv_aw_ready, mst_aw_valid, slv_ar_ready, mst_ar_valid
  );
  modport slave (
    input  slv_aw_valid, mst_aw_ready, slv_ar_valid, mst_ar_ready, b_hs, r_hs, r_last,
    output slv_aw_ready, mst_aw_valid, slv_ar_ready, mst_ar_valid
  );
endinterface

// File: rtl/axi_isolate_ctrl.sv
// axi_isolate_ctrl: gates AW/AR on isolate request, drains outstanding txns, caps outstanding per direction
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   isolate_i     : isolation request (level); isolated_o : port drained and gated
//   bus           : AW/AR gate handshakes plus observed B/R handshakes
//   underflow_o   : sticky response-without-request; timeout_o : sticky drain timeout
//   Optional drain timeout enabled by defining AXI_ISO_TIMEOUT_EN
module axi_isolate_ctrl #(
  parameter int unsigned MaxTxns       = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              isolate_i,
  output logic              isolated_o,
  output logic              underflow_o,
  output logic              timeout_o,
  axi_isolate_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(MaxTxns + 1);
  localparam logic [CW-1:0] CAP = CW'(MaxTxns);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, ISOLATED = 2'd2;
  if (MaxTxns < 1 || MaxTxns > 255 || TimeoutCycles < 1) begin : g_bad_param
    $error("axi_isolate_ctrl: MaxTxns must be 1..255 and TimeoutCycles >= 1");
  end
  logic [1:0] state, state_nx;
  logic [CW-1:0] aw_cnt, ar_cnt, aw_cnt_nx, ar_cnt_nx;
  logic aw_pend, ar_pend, aw_open, ar_open, aw_hs, ar_hs, r_done;
  logic aw_uf, ar_uf, drained, timeout_hit;
  // pend keeps a presented valid alive after the gate closes; rst_ni forces the gate shut in reset
  assign aw_open = rst_ni & ((state == RUN && aw_cnt < CAP) | aw_pend);
  assign ar_open = rst_ni & ((state == RUN && ar_cnt < CAP) | ar_pend);
  assign bus.mst_aw_valid = bus.slv_aw_valid & aw_open;
  assign bus.slv_aw_ready = bus.mst_aw_ready & aw_open;
  assign bus.mst_ar_valid = bus.slv_ar_valid & ar_open;
  assign bus.slv_ar_ready = bus.mst_ar_ready & ar_open;
  assign aw_hs = bus.mst_aw_valid & bus.mst_aw_ready;
  assign ar_hs = bus.mst_ar_valid & bus.mst_ar_ready;
  assign r_done = bus.r_hs & bus.r_last;
  assign aw_uf = bus.b_hs & !aw_hs & (aw_cnt == '0);
  assign ar_uf = r_done & !ar_hs & (ar_cnt == '0);
  always_comb begin
    aw_cnt_nx = (aw_hs && !bus.b_hs) ? aw_cnt + 1'b1 : (!aw_hs && bus.b_hs && !aw_uf) ? aw_cnt - 1'b1 : aw_cnt;
    ar_cnt_nx = (ar_hs && !r_done) ? ar_cnt + 1'b1 : (!ar_hs && r_done && !ar_uf) ? ar_cnt - 1'b1 : ar_cnt;
    drained = !aw_pend && !ar_pend && aw_cnt_nx == '0 && ar_cnt_nx == '0;
    state_nx = state == RUN ? (isolate_i ? DRAIN : RUN) :
               state == DRAIN ? (!isolate_i ? RUN : (drained || timeout_hit) ? ISOLATED : DRAIN) :
               state == ISOLATED ? (isolate_i ? ISOLATED : RUN) : RUN;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= RUN;
      aw_cnt      <= '0;
      ar_cnt      <= '0;
      aw_pend     <= 1'b0;
      ar_pend     <= 1'b0;
      isolated_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state       <= state_nx;
      aw_cnt      <= aw_cnt_nx;
      ar_cnt      <= ar_cnt_nx;
      aw_pend     <= bus.mst_aw_valid ? !bus.mst_aw_ready : aw_pend;
      ar_pend     <= bus.mst_ar_valid ? !bus.mst_ar_ready : ar_pend;
      isolated_o  <= state_nx == ISOLATED;
      underflow_o <= underflow_o | aw_uf | ar_uf;
    end
  end
`ifdef AXI_ISO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] t_cnt;
  // t_cnt holds 0 outside DRAIN so each drain attempt starts a fresh window
  assign timeout_hit = state == DRAIN && t_cnt == TW'(TimeoutCycles - 1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_cnt     <= '0;
      timeout_o <= 1'b0;
    end else begin
      t_cnt     <= state == DRAIN ? t_cnt + 1'b1 : '0;
      timeout_o <= state_nx == RUN ? 1'b0 : (state == DRAIN && state_nx == ISOLATED && !drained) ? 1'b1 : timeout_o;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif
endmodule
